systolic_output_collector: RTL and testbench

//  Downstream stage of the 1-D systolic array. Tracks which array inputs carried valid data and

---
 rtl/systolic_output_collector.sv | 99 +++++++++
 tb/tb_systolic_output_collector.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/systolic_output_collector.sv
// Output stage of a 1-D systolic array: aligns captures with launches through a tag line,
// applies optional ReLU, frames results and buffers them in a show-ahead FIFO.
module systolic_output_collector #(
  parameter int WIDTH         = 8,
  parameter int ARRAY_LATENCY = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int VEC_LEN       = 3,
  parameter bit RELU_EN       = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ce,
  input  logic                            launch,
  input  logic [WIDTH-1:0]                y_in,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            overflow
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  logic [ARRAY_LATENCY-1:0] tag_reg, tag_next;
  logic [CW-1:0]            frame_reg;
  logic [WIDTH:0]           mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]            count_reg, count_next;
  logic [WIDTH:0]           head_reg, head_next;
  logic                     overflow_reg;

  logic                     cap, frame_last, full, valid, pop, push;
  logic [WIDTH-1:0]         value;
  logic [WIDTH:0]           entry;

  // Tag line: bit i set means the sample launched i+1 ce-cycles ago was valid.
  assign tag_next[0] = launch;
  generate
    for (genvar gi = 1; gi < ARRAY_LATENCY; gi++) begin : g_tag
      assign tag_next[gi] = tag_reg[gi-1];
    end
  endgenerate

  assign cap        = ce & tag_reg[ARRAY_LATENCY-1];
  assign value      = (RELU_EN && y_in[WIDTH-1]) ? '0 : y_in;
  assign frame_last = (frame_reg == CW'(VEC_LEN - 1));
  assign entry      = {frame_last, value};

  assign full        = (count_reg == LW'(FIFO_DEPTH));
  assign valid       = (count_reg != '0);
  assign pop         = valid & out_ready;
  assign push        = cap & (~full | pop);
  assign rd_ptr_next = rd_ptr_reg + PW'(pop);
  assign count_next  = count_reg + LW'(push) - LW'(pop);

  // Registered head: the new capture goes straight to the head when nothing older remains.
  always_comb begin
    head_next = head_reg;
    if (count_next != '0) begin
      if (count_reg == LW'(pop)) head_next = entry;
      else                       head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg      <= '0;
      frame_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (ce) tag_reg <= tag_next;
      // Dropped captures still advance framing so frames stay aligned to the array.
      if (cap) frame_reg <= frame_last ? '0 : frame_reg + CW'(1);
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      if (cap && full && !pop) overflow_reg <= 1'b1;
    end
  end

  assign out_data  = head_reg[WIDTH-1:0];
  assign out_last  = head_reg[WIDTH];
  assign out_valid = valid;
  assign level     = count_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for systolic_output_collector: a vector table for reset/latency/ReLU/framing,
// plus hand-written sequences for ce stalls, overflow and draining while stalled.
module tb_systolic_output_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       launch = 1'b0;
  logic [7:0] y_in = 8'd0;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] level;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_output_collector #(
    .WIDTH(8), .ARRAY_LATENCY(3), .FIFO_DEPTH(4), .VEC_LEN(3), .RELU_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .launch(launch), .y_in(y_in),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow)
  );

  typedef struct {
    logic       r;
    logic       c;
    logic       l;
    logic [7:0] y;
    logic       rd;
    logic       ev;
    logic [7:0] ed;
    logic       el;
    logic [2:0] elev;
    logic       eov;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, c, l, input logic [7:0] y, input logic rd,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic [2:0] elev, input logic eov);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.y = y; v.rd = rd;
    v.ev = ev; v.ed = ed; v.el = el; v.elev = elev; v.eov = eov;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, then settle past the edge.
  task automatic step(input logic r, c, l, input logic [7:0] y, input logic rd);
    rst = r; ce = c; launch = l; y_in = y; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk5(input string name, input logic ev, input logic [7:0] ed,
                      input logic el, input logic [2:0] elev, input logic eov);
    $display("%s: valid=%0d data=%0d last=%0d level=%0d ovf=%0d", name,
             out_valid, $signed(out_data), out_last, level, overflow);
    check({name, ".valid"}, 32'(out_valid), 32'(ev));
    check({name, ".data"},  32'(out_data),  32'(ed));
    check({name, ".last"},  32'(out_last),  32'(el));
    check({name, ".level"}, 32'(level),     32'(elev));
    check({name, ".ovf"},   32'(overflow),  32'(eov));
  endtask

  initial begin
    // Reset, then tags launched before a reset must never surface.
    add(1,0,0,8'd0,0,   0,8'd0,0,3'd0,0);
    add(0,1,1,8'd5,0,   0,8'd0,0,3'd0,0);
    add(0,1,1,8'd5,0,   0,8'd0,0,3'd0,0);
    add(0,1,1,8'd5,0,   0,8'd0,0,3'd0,0);
    add(0,1,1,8'd5,0,   1,8'd5,0,3'd1,0);
    add(0,1,1,8'd5,0,   1,8'd5,0,3'd2,0);
    add(1,1,1,8'd5,0,   0,8'd0,0,3'd0,0);
    for (int i = 0; i < 4; i++) add(0,1,0,8'd5,0, 0,8'd0,0,3'd0,0);
    // Launch-to-output latency: y_in valid only on the third cycle after launch.
    add(0,1,1,8'd0,0,   0,8'd0,0,3'd0,0);
    add(0,1,0,8'd0,0,   0,8'd0,0,3'd0,0);
    add(0,1,0,8'd0,0,   0,8'd0,0,3'd0,0);
    add(0,1,0,8'd25,0,  1,8'd25,0,3'd1,0);
    add(0,1,0,8'd0,1,   0,8'd25,0,3'd0,0);
    // ReLU and framing from a fresh frame counter.
    add(1,1,0,8'd0,1,   0,8'd0,0,3'd0,0);
    for (int i = 0; i < 3; i++) add(0,1,1,8'd0,1, 0,8'd0,0,3'd0,0);
    add(0,1,1,8'hFB,1,  1,8'd0,0,3'd1,0);
    add(0,1,0,8'd7,1,   1,8'd7,0,3'd1,0);
    add(0,1,0,8'hFF,1,  1,8'd0,1,3'd1,0);
    add(0,1,0,8'd9,1,   1,8'd9,0,3'd1,0);
    add(0,1,0,8'd0,1,   0,8'd9,0,3'd0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].y, vecs[i].rd);
      chk5($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].elev, vecs[i].eov);
    end

    // ce stall: launches while ce=0 are ignored; capture on the third ce-high cycle.
    step(1,1,0,8'h33,0);
    step(0,1,1,8'h33,0);
    chk5("stall_c0", 0,8'd0,0,3'd0,0);
    for (int i = 1; i <= 4; i++) begin
      step(0,0,1,8'h33,0);
      chk5($sformatf("stall_c%0d", i), 0,8'd0,0,3'd0,0);
    end
    step(0,1,0,8'h33,0);
    chk5("stall_c5", 0,8'd0,0,3'd0,0);
    step(0,1,0,8'h33,0);
    chk5("stall_c6", 0,8'd0,0,3'd0,0);
    step(0,1,0,8'd42,0);
    chk5("stall_c7", 1,8'd42,0,3'd1,0);
    for (int i = 0; i < 3; i++) step(0,1,0,8'h33,0);
    chk5("stall_after", 1,8'd42,0,3'd1,0);

    // Overflow: six captures into four entries, then capture+pop while full.
    step(1,1,0,8'd0,0);
    for (int i = 0; i < 3; i++) step(0,1,1,8'd0,0);
    step(0,1,1,8'd10,0);  chk5("ovf_cap0", 1,8'd10,0,3'd1,0);
    step(0,1,1,8'd11,0);  chk5("ovf_cap1", 1,8'd10,0,3'd2,0);
    step(0,1,1,8'd12,0);  chk5("ovf_cap2", 1,8'd10,0,3'd3,0);
    step(0,1,0,8'd13,0);  chk5("ovf_cap3", 1,8'd10,0,3'd4,0);
    step(0,1,0,8'd14,0);  chk5("ovf_cap4", 1,8'd10,0,3'd4,1);
    step(0,1,1,8'd15,0);  chk5("ovf_cap5", 1,8'd10,0,3'd4,1);
    step(0,1,0,8'd0,0);
    step(0,1,0,8'd0,0);
    step(0,1,0,8'd99,1);  chk5("ovf_full_push", 1,8'd11,0,3'd4,1);
    step(0,1,0,8'd0,1);   chk5("ovf_drain0", 1,8'd12,1,3'd3,1);
    step(0,1,0,8'd0,1);   chk5("ovf_drain1", 1,8'd13,0,3'd2,1);
    step(0,1,0,8'd0,1);   chk5("ovf_drain2", 1,8'd99,0,3'd1,1);
    step(0,1,0,8'd0,1);   chk5("ovf_drain3", 0,8'd99,0,3'd0,1);

    // Drain while the array is stalled.
    step(1,1,0,8'd0,0);
    for (int i = 0; i < 3; i++) step(0,1,1,8'd0,0);
    step(0,1,0,8'd1,0);
    step(0,1,0,8'd2,0);
    step(0,1,0,8'd3,0);   chk5("drain_fill", 1,8'd1,0,3'd3,0);
    step(0,0,1,8'h77,1);  chk5("drain_pop0", 1,8'd2,0,3'd2,0);
    step(0,0,1,8'h77,1);  chk5("drain_pop1", 1,8'd3,1,3'd1,0);
    step(0,0,1,8'h77,1);  chk5("drain_pop2", 0,8'd3,1,3'd0,0);
    step(0,0,1,8'h77,1);  chk5("drain_idle", 0,8'd3,1,3'd0,0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
